// File: rtl/ahb_wrr_slave_arbiter_pkg.sv
// Shared types for the weighted round-robin AHB slave-port arbiter:
// AHB burst encoding, arbiter FSM states and the burst-length decode.
package ahb_wrr_slave_arbiter_pkg;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned BURST_LEN_W = 5;

  // Beat count of a burst; 0 marks undefined-length INCR.
  function automatic logic [BURST_LEN_W-1:0] burst_len(input hburst_type hb);
    case (hb)
      HB_SINGLE:           return 5'd1;
      HB_WRAP4,  HB_INCR4:  return 5'd4;
      HB_WRAP8,  HB_INCR8:  return 5'd8;
      HB_WRAP16, HB_INCR16: return 5'd16;
      default:             return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_wrr_slave_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first requester at or after
// ptr (wrapping past N-1 to 0) wins; one-hot grant plus its index.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned B = 2
) (
  input  logic [N-1:0] req,
  input  logic [B-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [B-1:0] index,
  output logic         valid
);

  logic [B-1:0] idx;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = B'((32'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        index      = idx;
      end
    end
  end

endmodule

// File: rtl/ahb_wrr_slave_arbiter.sv
// Weighted round-robin arbiter for one AHB slave port: grants whole bursts,
// counts beats from the winner's HBURST, and rotates once credit runs out.
module ahb_wrr_slave_arbiter
  import ahb_wrr_slave_arbiter_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned MASTER_BIT = $clog2(MASTER_NUM),
  parameter int unsigned WEIGHT_W   = 4,
  parameter int unsigned INCR_MAX   = 16
) (
  input  logic                                hclk,
  input  logic                                hreset,
  input  logic [MASTER_NUM-1:0]               hreq,
  input  logic [MASTER_NUM-1:0][2:0]          hburst,
  input  logic                                hwait,
  input  logic [MASTER_NUM-1:0][WEIGHT_W-1:0] cfg_weight,
  input  logic                                cfg_load,
  output logic [MASTER_NUM-1:0]               hgrant,
  output logic                                hsel,
  output logic [MASTER_BIT-1:0]               hmaster,
  output logic                                hlast
);

  localparam int unsigned CNT_W = $clog2((INCR_MAX > 16 ? INCR_MAX : 16) + 1);

  arb_state_e                          state_q, state_d;
  logic [MASTER_NUM-1:0]               grant_q, grant_d;
  logic [MASTER_BIT-1:0]               master_q, master_d;
  logic [MASTER_BIT-1:0]               ptr_q, ptr_d;
  logic [MASTER_NUM-1:0][WEIGHT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [CNT_W-1:0]                    len_q, len_d;

  logic [MASTER_BIT-1:0] next_owner, pick_ptr, pick_index;
  logic [MASTER_NUM-1:0] pick_grant;
  logic                  pick_valid;
  logic [WEIGHT_W-1:0]   credit_left;
  logic                  last_beat;

  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  assign next_owner = (master_q == MASTER_BIT'(MASTER_NUM - 1)) ? '0
                                                                : master_q + MASTER_BIT'(1);
  // From IDLE search from ptr; at burst end search from owner+1 in the same cycle.
  assign pick_ptr   = (state_q == ST_IDLE) ? ptr_q : next_owner;

  rr_pick #(
    .N(MASTER_NUM),
    .B(MASTER_BIT)
  ) u_pick (
    .req  (hreq),
    .ptr  (pick_ptr),
    .grant(pick_grant),
    .index(pick_index),
    .valid(pick_valid)
  );

  always_comb begin
    last_beat = 1'b0;
    if (len_q == '0) last_beat = !hreq[master_q] || (cnt_q == CNT_W'(INCR_MAX - 1));
    else             last_beat = (cnt_q == len_q - CNT_W'(1));
  end

  assign hlast   = (state_q == ST_BURST) && last_beat;
  assign hgrant  = grant_q;
  assign hsel    = |grant_q;
  assign hmaster = master_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    master_d    = master_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    credit_left = credit_q[master_q] - WEIGHT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_BURST;
          grant_d  = pick_grant;
          master_d = pick_index;
          len_d    = CNT_W'(burst_len(hburst_type'(hburst[pick_index])));
          cnt_d    = '0;
        end
      end
      ST_BURST: begin
        if (!hwait) begin
          if (!last_beat) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (credit_left != '0 && hreq[master_q]) begin
            credit_d[master_q] = credit_left;
            cnt_d              = '0;
            len_d              = CNT_W'(burst_len(hburst_type'(hburst[master_q])));
          end else begin
            credit_d[master_q] = eff_weight(cfg_weight[master_q]);
            ptr_d              = next_owner;
            cnt_d              = '0;
            if (pick_valid) begin
              grant_d  = pick_grant;
              master_d = pick_index;
              len_d    = CNT_W'(burst_len(hburst_type'(hburst[pick_index])));
            end else begin
              state_d  = ST_IDLE;
              grant_d  = '0;
              master_d = '0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_load) begin
      for (int unsigned i = 0; i < MASTER_NUM; i++) credit_d[i] = eff_weight(cfg_weight[i]);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      master_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      for (int unsigned i = 0; i < MASTER_NUM; i++) credit_q[i] <= WEIGHT_W'(1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: tb/tb_ahb_wrr_slave_arbiter.sv
// Directed bench for ahb_wrr_slave_arbiter: per-cycle expected outputs are
// queued with each stimulus vector and checked by an independent monitor.
module tb_ahb_wrr_slave_arbiter;

  logic             hclk = 1'b0;
  logic             hreset = 1'b1;
  logic [3:0]       hreq = '0;
  logic [3:0][2:0]  hburst = '0;
  logic             hwait = 1'b0;
  logic [3:0][3:0]  cfg_weight;
  logic             cfg_load = 1'b0;
  logic [3:0]       hgrant;
  logic             hsel;
  logic [1:0]       hmaster;
  logic             hlast;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] master;
    logic       last;
    logic       sel;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  exp_t        got, want;
  string       want_name;
  string       cur_test = "init";
  int          vec_no = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 hclk = ~hclk;

  ahb_wrr_slave_arbiter #(
    .MASTER_NUM(4),
    .MASTER_BIT(2),
    .WEIGHT_W  (4),
    .INCR_MAX  (16)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hreq      (hreq),
    .hburst    (hburst),
    .hwait     (hwait),
    .cfg_weight(cfg_weight),
    .cfg_load  (cfg_load),
    .hgrant    (hgrant),
    .hsel      (hsel),
    .hmaster   (hmaster),
    .hlast     (hlast)
  );

  // One cycle: drive inputs just after the edge, queue the outputs expected in that cycle.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic [2:0] burst,
                     input logic wt, input logic ld,
                     input logic [3:0] eg, input logic [1:0] em, input logic el);
    exp_t e;
    @(posedge hclk);
    #1;
    hreset   = rst;
    hreq     = req;
    for (int i = 0; i < 4; i++) hburst[i] = burst;
    hwait    = wt;
    cfg_load = ld;
    e = {eg, em, el, |eg};
    exp_q.push_back(e);
    name_q.push_back($sformatf("%s#%0d", cur_test, vec_no));
    vec_no++;
  endtask

  task automatic cycn(input int n, input logic rst, input logic [3:0] req, input logic [2:0] burst,
                      input logic wt, input logic ld,
                      input logic [3:0] eg, input logic [1:0] em, input logic el);
    repeat (n) cyc(rst, req, burst, wt, ld, eg, em, el);
  endtask

  initial begin
    forever begin
      @(negedge hclk);
      if (exp_q.size() > 0) begin
        want      = exp_q.pop_front();
        want_name = name_q.pop_front();
        got       = {hgrant, hmaster, hlast, hsel};
        compared++;
        if (got !== want) begin
          mismatched++;
          $display("FAIL %s: got hgrant=%b hmaster=%0d hlast=%b hsel=%b, want hgrant=%b hmaster=%0d hlast=%b hsel=%b",
                   want_name, got.grant, got.master, got.last, got.sel,
                   want.grant, want.master, want.last, want.sel);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) cfg_weight[i] = 4'd1;

    // single INCR4 from master 0, then idle
    cur_test = "t1_reset";
    cyc(1, 4'b0000, 3'd0, 0, 0, 4'b0000, 2'd0, 0);
    cur_test = "t1_incr4";
    cyc(0, 4'b0001, 3'd3, 0, 0, 4'b0000, 2'd0, 0);
    cycn(3, 0, 4'b0001, 3'd3, 0, 0, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0000, 3'd3, 0, 0, 4'b0001, 2'd0, 1);
    cyc(0, 4'b0000, 3'd3, 0, 0, 4'b0000, 2'd0, 0);

    // SINGLE bursts from masters 0 and 2 alternate with no bubble
    cur_test = "t2_single_rr";
    cyc(1, 4'b0000, 3'd0, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0101, 3'd0, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0101, 3'd0, 0, 0, 4'b0001, 2'd0, 1);
    cyc(0, 4'b0101, 3'd0, 0, 0, 4'b0100, 2'd2, 1);
    cyc(0, 4'b0101, 3'd0, 0, 0, 4'b0001, 2'd0, 1);
    cyc(0, 4'b0000, 3'd0, 0, 0, 4'b0100, 2'd2, 1);
    cyc(0, 4'b0000, 3'd0, 0, 0, 4'b0000, 2'd0, 0);

    // weight 3 on master 0: three INCR8 bursts, then master 1 gets one
    cfg_weight[0] = 4'd3;
    cur_test = "t3_weight";
    cyc(1, 4'b0000, 3'd5, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0011, 3'd5, 0, 1, 4'b0000, 2'd0, 0);
    repeat (3) begin
      cycn(7, 0, 4'b0011, 3'd5, 0, 0, 4'b0001, 2'd0, 0);
      cyc(0, 4'b0011, 3'd5, 0, 0, 4'b0001, 2'd0, 1);
    end
    cycn(7, 0, 4'b0011, 3'd5, 0, 0, 4'b0010, 2'd1, 0);
    cyc(0, 4'b0000, 3'd5, 0, 0, 4'b0010, 2'd1, 1);
    cyc(0, 4'b0000, 3'd5, 0, 0, 4'b0000, 2'd0, 0);
    cfg_weight[0] = 4'd1;

    // INCR ended by hreq drop on the 5th beat
    cur_test = "t4_incr_drop";
    cyc(1, 4'b0000, 3'd1, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0001, 3'd1, 0, 0, 4'b0000, 2'd0, 0);
    cycn(4, 0, 4'b0001, 3'd1, 0, 0, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0000, 3'd1, 0, 0, 4'b0001, 2'd0, 1);
    cyc(0, 4'b0000, 3'd1, 0, 0, 4'b0000, 2'd0, 0);

    // INCR held for 20 beats: forced end at beat 16, re-won, then dropped
    cur_test = "t4_incr_max";
    cyc(1, 4'b0000, 3'd1, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0001, 3'd1, 0, 0, 4'b0000, 2'd0, 0);
    cycn(15, 0, 4'b0001, 3'd1, 0, 0, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0001, 3'd1, 0, 0, 4'b0001, 2'd0, 1);
    cycn(3, 0, 4'b0001, 3'd1, 0, 0, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0000, 3'd1, 0, 0, 4'b0001, 2'd0, 1);
    cyc(0, 4'b0000, 3'd1, 0, 0, 4'b0000, 2'd0, 0);

    // WRAP4 with stalls on beat 2 and on the final beat
    cur_test = "t5_wrap4_wait";
    cyc(1, 4'b0000, 3'd2, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0001, 3'd2, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0001, 3'd2, 0, 0, 4'b0001, 2'd0, 0);
    cycn(3, 0, 4'b0001, 3'd2, 1, 0, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0001, 3'd2, 0, 0, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0001, 3'd2, 0, 0, 4'b0001, 2'd0, 0);
    cycn(2, 0, 4'b0001, 3'd2, 1, 0, 4'b0001, 2'd0, 1);
    cyc(0, 4'b0000, 3'd2, 0, 0, 4'b0001, 2'd0, 1);
    cyc(0, 4'b0000, 3'd2, 0, 0, 4'b0000, 2'd0, 0);

    // reset during beat 2 of INCR16 from master 2; next winner is lowest index
    cur_test = "t6_reset_mid";
    cyc(1, 4'b0000, 3'd7, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0100, 3'd7, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0100, 3'd7, 0, 0, 4'b0100, 2'd2, 0);
    cyc(1, 4'b1010, 3'd7, 0, 0, 4'b0100, 2'd2, 0);
    cyc(0, 4'b1010, 3'd7, 0, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b1010, 3'd7, 0, 0, 4'b0010, 2'd1, 0);
    cyc(1, 4'b0000, 3'd7, 0, 0, 4'b0010, 2'd1, 0);
    cyc(1, 4'b0000, 3'd7, 0, 0, 4'b0000, 2'd0, 0);

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge hclk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_wrr_slave_arbiter.md
# ahb_wrr_slave_arbiter

Weighted round-robin arbiter for one AHB slave port, sitting between the per-master request lines and the slave-side mux in the bus matrix. It grants whole bursts and tracks beat count from each winner's HBURST. Each master may keep ownership for up to its programmed weight of consecutive bursts before priority rotates. Handover is zero-bubble when another master is waiting.

## Interface
Parameters:
- MASTER_NUM, 4: number of requesting masters (2..16).
- MASTER_BIT, $clog2(MASTER_NUM): master index width.
- WEIGHT_W, 4: width of per-master weight/credit.
- INCR_MAX, 16: beat cap for undefined-length INCR bursts.

Ports:
- hclk  in  1  clock. One clock; reset is synchronous and active-high.
- hreset  in  1  synchronous active-high reset.
- hreq  in  MASTER_NUM  per-master bus request.
- hburst  in  MASTER_NUM x hburst_type  per-master burst type, sampled at grant.
- hwait  in  1  slave stall; beat accepted on a cycle with hsel=1, hwait=0.
- cfg_weight  in  MASTER_NUM x WEIGHT_W  bursts per turn; 0 is treated as 1.
- cfg_load  in  1  pulse: reload all credits from cfg_weight.
- hgrant  out  MASTER_NUM  one-hot registered grant.
- hsel  out  1  =|hgrant.
- hmaster  out  MASTER_BIT  index of current owner (0 when idle).
- hlast  out  1  high during the final beat of the current burst.

## Operation
- States: IDLE (no owner), BURST (owner holds bus).
- IDLE: if any hreq, pick a winner by rotating priority starting at ptr; register hgrant/hmaster; latch the winner's hburst; beat counter = 0; go BURST. If no hreq, stay in IDLE.
- Burst length: SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16. INCR ends on the accepted beat where the owner's hreq=0, or at beat INCR_MAX.
- BURST: the beat counter increments on each accepted beat. hlast = owner's final beat (count==len-1, or the INCR end condition). The burst ends on an accepted beat with hlast=1.
- At burst end:
  - Owner credit decrements.
  - If the remaining credit is >0 and the owner's hreq=1, re-grant the owner: new hburst latched, counter cleared.
  - Otherwise reload the owner's credit from weight, set ptr=owner+1 (mod MASTER_NUM), and pick the next winner from ptr in the same cycle. If there is no request, go to IDLE.
- A master that drops hreq mid fixed-length burst keeps the grant until the burst completes. Bursts are never truncated except by reset.
- cfg_load sets every credit to its weight in any state. The in-flight burst is unaffected. If cfg_load coincides with burst end, the reload wins over the decrement.

## Timing
- Reset values: hgrant=0, hsel=0, hmaster=0, hlast=0, state=IDLE, ptr=0, all credits=1, counter=0.
- hreq in IDLE produces hgrant in the next cycle (1-cycle latency).
- Handover: the clock edge ending the last accepted beat loads the new owner's hgrant. There is no idle cycle between bursts.
- The counter freezes while hwait=1. hlast holds through stalls.
- Wrap-around: ptr and the rotating search wrap from MASTER_NUM-1 to 0.
- Reset asserted mid-burst clears everything on the next edge. No hlast is generated.

## Structure
- AHB_package already holds hburst_type. Add a burst_len function (hburst_type to beat count, INCR returning 0 as "undefined") and the state enum.
- Sub-module rr_pick: combinational rotating-priority one-hot picker (req, ptr to grant, index, valid).
- The top level holds the FSM, the credit array, ptr, and the beat counter.

## Test plan
- Reset, then hreq=4'b0001 with hburst=INCR4, hwait=0 -> hgrant=0001 one cycle later, hlast on the 4th beat, then IDLE.
- hreq=4'b0101, weights all 1, SINGLE bursts -> grants alternate 0001, 0100, 0001 with no idle cycle between them.
- cfg_weight[0]=3 with cfg_load, master 0 and master 1 requesting continuously with INCR8 -> master 0 owns 3 bursts (24 beats), then master 1 owns 1 burst.
- INCR burst, owner drops hreq at beat 5 -> hlast on that beat, grant released. Owner holding INCR for 20 beats -> forced end at beat 16.
- hwait=1 for 3 cycles mid WRAP4 -> counter holds, hlast holds, burst completes after 4 accepted beats.
- hreset asserted during beat 2 of INCR16 -> all outputs 0 next cycle, ptr=0, the next grant goes to the lowest requesting index.
